// File: rtl/if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the five-stage MIPS pipeline.
// Holds the PC, handles stall / branch / jump / flush, and inserts bubbles on redirect.
module if_id_stage #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                stall,
  input  logic                jump,
  input  logic                if_flush,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [31:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc4,
  output logic                if_id_valid,
  output logic [31:0]         fetch_count,
  output logic [15:0]         redirect_count
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_aligned;

  assign pc_plus4       = pc + PC_WIDTH'(4);
  assign jump_target    = {if_id_pc4[PC_WIDTH-1:28], if_id_instr[25:0], 2'b00};
  assign branch_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign imem_addr      = pc;

  // Stall freezes everything; a redirect request simply stays asserted until it is honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc4      <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
      redirect_count <= '0;
    end else if (!stall) begin
      if (branch_taken || jump) begin
        pc             <= branch_taken ? branch_aligned : jump_target;
        if_id_instr    <= NOP_INSTR;
        if_id_pc4      <= '0;
        if_id_valid    <= 1'b0;
        redirect_count <= redirect_count + 16'd1;
      end else if (if_flush) begin
        pc          <= pc_plus4;
        if_id_instr <= NOP_INSTR;
        if_id_pc4   <= '0;
        if_id_valid <= 1'b0;
      end else begin
        pc          <= pc_plus4;
        if_id_instr <= imem_data;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage: free-run fetch, branch, jump, stall,
// branch/jump priority, flush, PC wrap and asynchronous reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        jump;
  logic        if_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;

  int totalCount = 0;
  int badCount   = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .jump(jump), .if_flush(if_flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count), .redirect_count(redirect_count)
  );

  // Instruction memory: word index + 1, with a jump word and a jump-target word planted.
  always_comb begin
    imem_data = (imem_addr >> 2) + 32'd1;
    if (imem_addr == 32'h1000_000C) imem_data = 32'h0800_0040;
    else if (imem_addr == 32'h1000_0100) imem_data = 32'h0800_0123;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid, input logic [31:0] fc,
                          input logic [31:0] rc);
    checkOutput({tag, ".addr"},  imem_addr, addr);
    checkOutput({tag, ".instr"}, if_id_instr, instr);
    checkOutput({tag, ".pc4"},   if_id_pc4, pc4);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    checkOutput({tag, ".fcnt"},  fetch_count, fc);
    checkOutput({tag, ".rcnt"},  {16'b0, redirect_count}, rc);
  endtask

  task automatic applyStimulus(input logic s, input logic j, input logic f, input logic b,
                               input logic [31:0] bt);
    stall = s; jump = j; if_flush = f; branch_taken = b; branch_target = bt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0);
    #12;
    checkAll("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 4; k++) begin
      step();
      checkAll("freerun", 32'(4 * k), 32'(k), 32'(4 * k), 1'b1, 32'(k), 0);
    end

    applyStimulus(0, 0, 0, 1, 32'h0000_0203);
    step();
    checkAll("beq", 32'h200, 32'h0, 32'h0, 1'b0, 4, 1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    step();
    checkAll("beq_tgt", 32'h204, 32'h81, 32'h204, 1'b1, 5, 1);

    applyStimulus(0, 0, 0, 1, 32'h1000_000C);
    step();
    checkAll("beq2", 32'h1000_000C, 32'h0, 32'h0, 1'b0, 5, 2);
    applyStimulus(0, 0, 0, 0, 32'h0);
    step();
    checkAll("jword", 32'h1000_0010, 32'h0800_0040, 32'h1000_0010, 1'b1, 6, 2);

    applyStimulus(0, 1, 0, 0, 32'h0);
    step();
    checkAll("jump", 32'h1000_0100, 32'h0, 32'h0, 1'b0, 6, 3);
    applyStimulus(0, 0, 0, 0, 32'h0);
    step();
    checkAll("jump_tgt", 32'h1000_0104, 32'h0800_0123, 32'h1000_0104, 1'b1, 7, 3);

    // Jump to {4'h1, 26'h123, 2'b00} is held off by three stalled edges.
    applyStimulus(1, 1, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkAll("stall", 32'h1000_0104, 32'h0800_0123, 32'h1000_0104, 1'b1, 7, 3);
    end
    applyStimulus(0, 1, 0, 0, 32'h0);
    step();
    checkAll("stall_rel", 32'h1000_048C, 32'h0, 32'h0, 1'b0, 7, 4);

    applyStimulus(0, 1, 0, 1, 32'h3000_0000);
    step();
    checkAll("both", 32'h3000_0000, 32'h0, 32'h0, 1'b0, 7, 5);
    applyStimulus(0, 0, 0, 0, 32'h0);
    step();
    checkAll("fetch", 32'h3000_0004, 32'h0C00_0001, 32'h3000_0004, 1'b1, 8, 5);
    applyStimulus(0, 0, 1, 0, 32'h0);
    step();
    checkAll("flush", 32'h3000_0008, 32'h0, 32'h0, 1'b0, 8, 5);

    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
    step();
    checkAll("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 8, 6);
    applyStimulus(0, 0, 0, 0, 32'h0);
    step();
    checkAll("wrap", 32'h0, 32'h4000_0000, 32'h0, 1'b1, 9, 6);

    // Drop reset between edges, in the middle of a stalled redirect.
    applyStimulus(1, 1, 0, 0, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    checkAll("post_rst", 32'h4, 32'h1, 32'h4, 1'b1, 1, 0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
